// File: rtl/event_encoder_8x3.sv
// Sequential 8-to-3 event encoder: latches event pulses and streams their indices over valid/ready.
// Define ENCODER_ROUND_ROBIN_EN for round-robin selection; the default is fixed lowest-index priority.
module event_encoder_8x3 #(
   parameter int SIZE_IN  = 8,
   parameter int SIZE_OUT = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SIZE_IN-1:0]  in,
   output logic [SIZE_OUT-1:0] out,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [SIZE_IN-1:0]  pending,
   output logic                merged
);

   typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

   state_t              state_r;
   logic [SIZE_OUT-1:0] out_r;
   logic                out_valid_r;
   logic [SIZE_IN-1:0]  pending_r;
   logic                merged_r;

   logic                hs_s;
   logic [SIZE_IN-1:0]  out_onehot_s;
   logic [SIZE_IN-1:0]  clr_s;
   logic [SIZE_IN-1:0]  pending_next_s;
   logic [SIZE_IN-1:0]  remain_s;
   logic                merge_hit_s;
   logic [SIZE_OUT-1:0] sel_s;

`ifdef ENCODER_ROUND_ROBIN_EN
   logic [SIZE_OUT-1:0] rr_r;
   logic [SIZE_OUT-1:0] rr_eff_s;

   // First set bit at or after (last+1), wrapping around the event vector.
   function automatic logic [SIZE_OUT-1:0] sel_rr(input logic [SIZE_IN-1:0] v,
                                                  input logic [SIZE_OUT-1:0] last);
      logic [SIZE_OUT-1:0] r;
      logic                found;
      int                  idx;
      r     = {SIZE_OUT{1'b0}};
      found = 1'b0;
      for (int i = 1; i <= SIZE_IN; i++) begin
         idx   = (int'(last) + i) % SIZE_IN;
         r     = (!found && v[idx]) ? SIZE_OUT'(idx) : r;
         found = found | v[idx];
      end
      return r;
   endfunction
`else
   function automatic logic [SIZE_OUT-1:0] sel_fixed(input logic [SIZE_IN-1:0] v);
      logic [SIZE_OUT-1:0] r;
      r = {SIZE_OUT{1'b0}};
      for (int i = SIZE_IN - 1; i >= 0; i--) begin
         r = v[i] ? SIZE_OUT'(i) : r;
      end
      return r;
   endfunction
`endif

   // Next-state terms: clear on handshake, set from in (set wins), merge detection, selection.
   always_comb begin
      out_onehot_s        = {SIZE_IN{1'b0}};
      out_onehot_s[out_r] = 1'b1;
      hs_s                = out_valid_r & out_ready;
      clr_s               = hs_s ? out_onehot_s : {SIZE_IN{1'b0}};
      pending_next_s      = (pending_r & ~clr_s) | in;
      remain_s            = (pending_next_s & ~out_onehot_s) | (in & out_onehot_s);
      merge_hit_s         = |(in & pending_r & ~clr_s);
`ifdef ENCODER_ROUND_ROBIN_EN
      // The search after a handshake starts just past the index being retired.
      rr_eff_s            = hs_s ? out_r : rr_r;
      sel_s               = sel_rr(pending_next_s, rr_eff_s);
`else
      sel_s               = sel_fixed(pending_next_s);
`endif
   end

   // Pending register, sticky merge flag and the IDLE/PRESENT presentation FSM.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         out_r       <= {SIZE_OUT{1'b0}};
         out_valid_r <= 1'b0;
         pending_r   <= {SIZE_IN{1'b0}};
         merged_r    <= 1'b0;
`ifdef ENCODER_ROUND_ROBIN_EN
         rr_r        <= SIZE_OUT'(SIZE_IN - 1);
`endif
      end else begin
         pending_r <= pending_next_s;
         merged_r  <= merged_r | merge_hit_s;
`ifdef ENCODER_ROUND_ROBIN_EN
         rr_r      <= rr_eff_s;
`endif
         case (state_r)
            IDLE: begin
               if (|pending_next_s) begin
                  out_r       <= sel_s;
                  out_valid_r <= 1'b1;
                  state_r     <= PRESENT;
               end else begin
                  out_valid_r <= 1'b0;
               end
            end
            PRESENT: begin
               // Without out_ready the presented index is frozen, even if lower events arrive.
               if (out_ready) begin
                  if (|remain_s) begin
                     out_r <= sel_s;
                  end else begin
                     out_valid_r <= 1'b0;
                     state_r     <= IDLE;
                  end
               end else begin
                  out_valid_r <= 1'b1;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign out       = out_r;
   assign out_valid = out_valid_r;
   assign pending   = pending_r;
   assign merged    = merged_r;

endmodule

// File: doc/event_encoder_8x3.md
Name: event_encoder_8x3

Overview:
- Sequential 8-to-3 encoder; inverse of the 3x8 select decoder.
- Captures pulsed one-hot or multi-hot event lines into a pending register.
- Emits each pending event as a binary index, one per accepted valid/ready handshake.
- Sits between event sources (buttons, decoded strobes) and a consumer that needs a 3-bit select/index stream.

Parameters:
- SIZE_IN, 8, number of event lines (power of two, 2..16).
- SIZE_OUT, 3, index width; must equal log2(SIZE_IN).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low; sampled on rising edge of clk.
- in  input  SIZE_IN  event pulses; bit k high for one or more cycles requests index k.
- out  output  SIZE_OUT  index of the presented event; registered.
- out_valid  output  1  out holds a valid index; registered.
- out_ready  input  1  consumer accepts out when out_valid && out_ready at a clock edge.
- pending  output  SIZE_IN  current pending-event register.
- merged  output  1  sticky flag: an event was absorbed into an already-pending bit.

Behaviour:
- Reset (rst_n=0 at edge): pending=0, out=0, out_valid=0, merged=0, state=IDLE, rr pointer=SIZE_IN-1. Reset overrides all other activity, mid-handshake included.
- Handshake: hs = out_valid && out_ready. clr = one-hot(out) when hs, else 0.
- pending_next = (pending & ~clr) | in.
- Simultaneous clear and set of the same bit: set wins. The bit stays pending and counts as a new event.
- Merge: merged is set, and stays set until reset, when for some k in[k]=1, pending[k]=1 and clr[k]=0. The event is not duplicated.
- Selection function sel(v): lowest set index of v (fixed priority). With the optional feature, see below.
- State machine, two states:
  - IDLE (out_valid=0): if pending_next != 0, load out=sel(pending_next), set out_valid=1, go PRESENT. Otherwise stay.
  - PRESENT (out_valid=1):
    - If !out_ready: hold out and out_valid unchanged. Newly arriving lower indices must not alter out.
    - If out_ready and (pending_next & ~one-hot(out) | (in & one-hot(out))) != 0: load out=sel(pending_next), stay PRESENT. This gives back-to-back throughput, one index per cycle.
    - If out_ready and nothing remains: out_valid=0, go IDLE. out keeps its last value.
- Latency: event pulse in cycle N with an idle block gives out_valid=1 with the index in cycle N+1.
- The presented bit remains set in pending until its handshake.
- in=0 with pending=0: outputs stay idle indefinitely.

Optional Feature:
- Macro: ENCODER_ROUND_ROBIN_EN.
- Defined:
  - sel(v) searches upward from (rr+1) mod SIZE_IN, wrapping, and returns the first set bit.
  - rr updates to out on every hs.
  - Reset rr=SIZE_IN-1, so the first search starts at 0.
- Undefined: fixed lowest-index priority; no rr register is synthesized.
- Handshake, latency and merge rules are identical in both builds.

Test Plan:
- Burst drain: out_ready=1, in=8'b1010_0100 for one cycle at N -> out=2,5,7 with out_valid=1 in cycles N+1, N+2, N+3; out_valid=0 at N+4; pending=0; merged=0.
- Backpressure hold: out_ready=0, pulse in=8'h80, then two cycles later pulse in=8'h01 -> out=7 held stable. Raise out_ready -> out=7 accepted, then out=0, then idle.
- Merge: pending=8'h08 presented with out_ready=0, pulse in[3] again -> merged=1 next cycle. After out_ready=1, index 3 is emitted exactly once.
- Set-wins: out=4 presented, out_ready=1 and in[4]=1 in the same cycle -> next cycle out=4, out_valid=1, pending[4]=1, merged=0.
- Reset mid-operation: pending=8'hFF, out_valid=1, drive rst_n=0 for one edge -> pending=0, out=0, out_valid=0, merged=0. Normal operation resumes after rst_n=1.
- Priority mode: pulse in=8'h0A, accept out=1, and pulse in[0] in the handshake cycle -> without the macro the next indices are 0 then 3; with ENCODER_ROUND_ROBIN_EN they are 3 then 0.
